sat_addsub_pipe: RTL and testbench

Parametrised, pipelined successor to the datapath's 16-bit saturating add/sub. It supports full-width or packed-lane (SIMD) saturating addition and subtraction. Each lane precomputes carry-select sums in stage 1; stage 2 resolves carries across lanes and saturates the result. A valid/ready handshake on both sides lets it sit between the ALU issue logic and the writeback stage. Per-lane sticky saturation flags are provided for debug/status.

---
 rtl/sat_addsub_pkg.sv | 28 ++
 rtl/sat_addsub_pipe_lane.sv | 36 +++
 rtl/sat_addsub_pipe.sv | 189 ++++++++++++++++++
 tb/tb_sat_addsub_pipe.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/sat_addsub_pkg.sv
// rtl/sat_addsub_pkg.sv - shared constants and saturation helpers for the saturating add/sub pipe
// Saturation patterns are built as constant functions so widths stay parameter-driven.
package sat_addsub_pkg;

  localparam int MAXW = 64;

  localparam logic MODE_FULL   = 1'b0;
  localparam logic MODE_PACKED = 1'b1;

  function automatic logic [MAXW-1:0] sat_max(input int w);
    logic [MAXW-1:0] v;
    v = '0;
    for (int k = 0; k < MAXW; k++) begin
      if (k < w - 1) v[k] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [MAXW-1:0] sat_min(input int w);
    logic [MAXW-1:0] v;
    v = '0;
    for (int k = 0; k < MAXW; k++) begin
      if (k == w - 1) v[k] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/sat_addsub_pipe_lane.sv
// rtl/sat_addsub_pipe_lane.sv - one lane of carry-select sums with group P/G and MSB carry terms
// b is already inverted for subtraction; the caller picks cin later.
module sat_lane_add #(
  parameter int LANE = 4
) (
  input  logic [LANE-1:0] a,
  input  logic [LANE-1:0] b,
  output logic [LANE-1:0] sum0,
  output logic [LANE-1:0] sum1,
  output logic            p,
  output logic            g,
  output logic            cm0,
  output logic            cm1,
  output logic            co0,
  output logic            co1
);

  logic [LANE:0] w_s0;
  logic [LANE:0] w_s1;

  assign w_s0 = {1'b0, a} + {1'b0, b};
  assign w_s1 = w_s0 + {{LANE{1'b0}}, 1'b1};

  assign sum0 = w_s0[LANE-1:0];
  assign sum1 = w_s1[LANE-1:0];
  assign co0  = w_s0[LANE];
  assign co1  = w_s1[LANE];

  assign p = &(a ^ b);
  assign g = w_s0[LANE];

  // Carry into the MSB recovered from the MSB sum bit and its operands.
  assign cm0 = w_s0[LANE-1] ^ a[LANE-1] ^ b[LANE-1];
  assign cm1 = w_s1[LANE-1] ^ a[LANE-1] ^ b[LANE-1];

endmodule

// File: rtl/sat_addsub_pipe.sv
// rtl/sat_addsub_pipe.sv - two-stage full-width / packed-lane saturating add/sub with valid/ready
// Stage 1 registers per-lane carry-select sums; stage 2 resolves carries, saturates and holds the output.
module sat_addsub_pipe
  import sat_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANE  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    padd,
  input  logic                    sub,
  input  logic [WIDTH-1:0]        a,
  input  logic [WIDTH-1:0]        b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        s,
  output logic                    cout,
  output logic [WIDTH/LANE-1:0]   ovfl,
  output logic [WIDTH/LANE-1:0]   sat_sticky,
  input  logic                    clr_sticky
);

  localparam int NLANE = WIDTH / LANE;

  localparam logic [MAXW-1:0]  LANE_MAX_X = sat_max(LANE);
  localparam logic [MAXW-1:0]  LANE_MIN_X = sat_min(LANE);
  localparam logic [MAXW-1:0]  FULL_MAX_X = sat_max(WIDTH);
  localparam logic [MAXW-1:0]  FULL_MIN_X = sat_min(WIDTH);
  localparam logic [LANE-1:0]  LANE_MAX   = LANE_MAX_X[LANE-1:0];
  localparam logic [LANE-1:0]  LANE_MIN   = LANE_MIN_X[LANE-1:0];
  localparam logic [WIDTH-1:0] FULL_MAX   = FULL_MAX_X[WIDTH-1:0];
  localparam logic [WIDTH-1:0] FULL_MIN   = FULL_MIN_X[WIDTH-1:0];

  typedef struct packed {
    logic [WIDTH-1:0] sum0;
    logic [WIDTH-1:0] sum1;
    logic [NLANE-1:0] p;
    logic [NLANE-1:0] g;
    logic [NLANE-1:0] cm0;
    logic [NLANE-1:0] cm1;
    logic [NLANE-1:0] co0;
    logic [NLANE-1:0] co1;
    logic             padd;
    logic             sub;
  } st1_t;

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_sum0;
  logic [WIDTH-1:0] w_sum1;
  logic [NLANE-1:0] w_p;
  logic [NLANE-1:0] w_g;
  logic [NLANE-1:0] w_cm0;
  logic [NLANE-1:0] w_cm1;
  logic [NLANE-1:0] w_co0;
  logic [NLANE-1:0] w_co1;
  st1_t             w_st1_d;

  st1_t             r_st1;
  logic             r_v1;
  logic             r_v2;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic [NLANE-1:0] r_ovfl;
  logic [NLANE-1:0] r_sticky;

  logic             w_ld1;
  logic             w_ld2;
  logic             w_xfer;
  logic [NLANE:0]   w_c;
  logic [WIDTH-1:0] w_raw;
  logic [NLANE-1:0] w_lane_ovf;
  logic [WIDTH-1:0] w_sat;
  logic [NLANE-1:0] w_ovf;
  logic             w_cout;

  assign w_b_eff = sub ? ~b : b;

  for (genvar gi = 0; gi < NLANE; gi++) begin : g_lane
    sat_lane_add #(.LANE(LANE)) u_lane (
      .a    (a[gi*LANE +: LANE]),
      .b    (w_b_eff[gi*LANE +: LANE]),
      .sum0 (w_sum0[gi*LANE +: LANE]),
      .sum1 (w_sum1[gi*LANE +: LANE]),
      .p    (w_p[gi]),
      .g    (w_g[gi]),
      .cm0  (w_cm0[gi]),
      .cm1  (w_cm1[gi]),
      .co0  (w_co0[gi]),
      .co1  (w_co1[gi])
    );
  end

  always_comb begin
    w_st1_d      = '0;
    w_st1_d.sum0 = w_sum0;
    w_st1_d.sum1 = w_sum1;
    w_st1_d.p    = w_p;
    w_st1_d.g    = w_g;
    w_st1_d.cm0  = w_cm0;
    w_st1_d.cm1  = w_cm1;
    w_st1_d.co0  = w_co0;
    w_st1_d.co1  = w_co1;
    w_st1_d.padd = padd;
    w_st1_d.sub  = sub;
  end

  assign w_ld2    = !r_v2 | out_ready;
  assign w_ld1    = !r_v1 | w_ld2;
  assign w_xfer   = r_v2 & out_ready;
  assign in_ready = w_ld1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_st1 <= '0;
    end else if (w_ld1) begin
      r_v1 <= in_valid;
      if (in_valid) r_st1 <= w_st1_d;
    end
  end

  // Packed lanes each see cin = sub; full mode ripples lane P/G from cin = sub.
  always_comb begin
    w_c        = '0;
    w_raw      = '0;
    w_lane_ovf = '0;
    w_c[0]     = r_st1.sub;
    for (int i = 0; i < NLANE; i++) begin
      if (r_st1.padd == MODE_PACKED) w_c[i+1] = r_st1.sub;
      else                           w_c[i+1] = r_st1.g[i] | (r_st1.p[i] & w_c[i]);
      w_raw[i*LANE +: LANE] = w_c[i] ? r_st1.sum1[i*LANE +: LANE] : r_st1.sum0[i*LANE +: LANE];
      w_lane_ovf[i] = (w_c[i] ? r_st1.cm1[i] : r_st1.cm0[i])
                    ^ (w_c[i] ? r_st1.co1[i] : r_st1.co0[i]);
    end
  end

  always_comb begin
    w_sat  = w_raw;
    w_ovf  = '0;
    w_cout = 1'b0;
    if (r_st1.padd == MODE_PACKED) begin
      w_ovf = w_lane_ovf;
      for (int i = 0; i < NLANE; i++) begin
        if (w_lane_ovf[i]) begin
          w_sat[i*LANE +: LANE] = w_raw[i*LANE + LANE - 1] ? LANE_MAX : LANE_MIN;
        end
      end
    end else begin
      w_ovf[NLANE-1] = w_lane_ovf[NLANE-1];
      w_cout         = w_c[NLANE];
      if (w_lane_ovf[NLANE-1]) w_sat = w_raw[WIDTH-1] ? FULL_MAX : FULL_MIN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2   <= 1'b0;
      r_s    <= '0;
      r_cout <= 1'b0;
      r_ovfl <= '0;
    end else if (w_ld2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_s    <= w_sat;
        r_cout <= w_cout;
        r_ovfl <= w_ovf;
      end
    end
  end

  // A clear and a new saturation in the same cycle keep the new bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= '0;
    end else if (clr_sticky | w_xfer) begin
      r_sticky <= (clr_sticky ? '0 : r_sticky) | (w_xfer ? r_ovfl : '0);
    end
  end

  assign out_valid  = r_v2;
  assign s          = r_s;
  assign cout       = r_cout;
  assign ovfl       = r_ovfl;
  assign sat_sticky = r_sticky;

endmodule

// File: tb/tb_sat_addsub_pipe.sv
// tb/tb_sat_addsub_pipe.sv - directed self-checking bench for sat_addsub_pipe
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sat_addsub_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        padd;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        cout;
  logic [3:0]  ovfl;
  logic [3:0]  sat_sticky;
  logic        clr_sticky;

  int n_checks;
  int n_errors;
  int nin;
  int nout;

  sat_addsub_pipe #(.WIDTH(16), .LANE(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .padd       (padd),
    .sub        (sub),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .s          (s),
    .cout       (cout),
    .ovfl       (ovfl),
    .sat_sticky (sat_sticky),
    .clr_sticky (clr_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic pd, input logic sb,
                       input logic [15:0] av, input logic [15:0] bv,
                       input logic [15:0] es, input logic ec, input logic [3:0] eo);
    @(negedge clk);
    padd = pd; sub = sb; a = av; b = bv; in_valid = 1'b1;
    #1;
    check_val({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check_val({tag, "_early"}, out_valid, 0);
    @(negedge clk);
    check_val({tag, "_valid"}, out_valid, 1);
    check_val({tag, "_s"}, s, es);
    check_val({tag, "_cout"}, cout, ec);
    check_val({tag, "_ovfl"}, ovfl, eo);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b1; in_valid = 1'b0; padd = 1'b0; sub = 1'b0; a = '0; b = '0;
    out_ready = 1'b1; clr_sticky = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_s", s, 0);
    check_val("rst_cout", cout, 0);
    check_val("rst_ovfl", ovfl, 0);
    check_val("rst_sticky", sat_sticky, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_in_ready", in_ready, 1);

    do_op("full_add_pos", 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 4'b1000);
    @(negedge clk);
    check_val("sticky_after_first", sat_sticky, 4'b1000);
    do_op("full_sub_neg", 1'b0, 1'b1, 16'h8000, 16'h0001, 16'h8000, 1'b1, 4'b1000);
    do_op("full_add_wrap", 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 4'b0000);
    do_op("pk_sub", 1'b1, 1'b1, 16'h1234, 16'h1111, 16'h0123, 1'b0, 4'b0000);
    do_op("pk_add_pos", 1'b1, 1'b0, 16'h7777, 16'h1111, 16'h7777, 1'b0, 4'hF);
    do_op("pk_add_neg", 1'b1, 1'b0, 16'h8888, 16'h8888, 16'h8888, 1'b0, 4'hF);
    @(negedge clk);
    check_val("sticky_accum", sat_sticky, 4'hF);

    // Backpressure: out_ready low for the first 5 cycles, 4 ops offered back to back
    nin = 0; nout = 0;
    padd = 1'b0; sub = 1'b0; b = 16'h0010;
    for (int t = 0; t < 30 && nout < 4; t++) begin
      @(negedge clk);
      out_ready = (t >= 5);
      if (nin < 4) begin
        in_valid = 1'b1;
        a = 16'h0001 + 16'(nin);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (t == 2) begin
        check_val("bp_in_ready_low", in_ready, 0);
        check_val("bp_accepted", nin, 2);
      end
      if (t == 4) check_val("bp_hold", {out_valid, s}, {1'b1, 16'h0011});
      if (out_valid && out_ready) begin
        check_val($sformatf("bp_out%0d", nout), s, 16'h0011 + 16'(nout));
        nout++;
      end
      if (in_valid && in_ready) nin++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    check_val("bp_count", nout, 4);

    // Sticky: clear, lane-2 saturation, then clear together with a lane-0 saturating transfer
    @(negedge clk);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    check_val("stk_cleared", sat_sticky, 0);
    do_op("stk_l2", 1'b1, 1'b0, 16'h0700, 16'h0100, 16'h0700, 1'b0, 4'b0100);
    @(negedge clk);
    check_val("stk_l2_set", sat_sticky, 4'b0100);
    out_ready = 1'b0;
    padd = 1'b1; sub = 1'b0; a = 16'h0007; b = 16'h0001; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 5 && !out_valid; k++) @(negedge clk);
    check_val("stk_l0_valid", out_valid, 1);
    check_val("stk_l0_s", s, 16'h0007);
    check_val("stk_l0_ovfl", ovfl, 4'b0001);
    clr_sticky = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    check_val("stk_clr_set", sat_sticky, 4'b0001);
    check_val("stk_drained", out_valid, 0);

    // Reset with two ops in flight
    out_ready = 1'b0; padd = 1'b0; sub = 1'b0;
    a = 16'h0001; b = 16'h0002; in_valid = 1'b1;
    @(negedge clk);
    a = 16'h0003; b = 16'h0004;
    @(negedge clk);
    in_valid = 1'b0;
    check_val("mid_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", out_valid, 0);
    check_val("mid_rst_s", s, 0);
    check_val("mid_rst_cout", cout, 0);
    check_val("mid_rst_ovfl", ovfl, 0);
    check_val("mid_rst_sticky", sat_sticky, 0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check_val("post_rst_idle0", out_valid, 0);
    @(negedge clk);
    check_val("post_rst_idle1", out_valid, 0);
    do_op("post_rst", 1'b0, 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
